hazard_detection_unit_param: RTL and testbench

//   Parametrised hazard detection unit for the 5-stage MIPS pipeline, placed at the
//   ID stage. Detects load-use hazards, operand hazards on branches resolved in ID,
//   and structural/data hazards against a multi-cycle multiply/divide unit (MDU).
//   On a hazard it freezes the PC and IF/ID and bubbles the ID/EX control word.

---
 rtl/hazard_detection_unit_param.sv | 171 +++++++++++++++++
 tb/tb_hazard_detection_unit_param.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detection_unit_param.sv
// Hazard detection unit for the ID stage of a 5-stage MIPS pipeline.
// Raises a stall for load-use hazards, for branch operand hazards when
// branches resolve in ID, and for HI/LO or MDU accesses while the
// multi-cycle multiply/divide unit is still busy. On a stall the PC and
// IF/ID are frozen and a bubble is pushed into ID/EX. A saturating
// counter records how many cycles were lost to stalls.
module hazard_detection_unit_param #(
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_IN_ID = 1,
    parameter int MDU_LATENCY  = 32,
    parameter int CNT_W        = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_IsBranch,
    input  logic                  ID_IsMDU,
    input  logic                  ID_ReadsHiLo,
    input  logic                  EX_MemRead,
    input  logic                  EX_RegWrite,
    input  logic [REG_ADDR_W-1:0] EX_WriteReg,
    input  logic                  MEM_MemRead,
    input  logic [REG_ADDR_W-1:0] MEM_WriteReg,
    output logic                  PC_WriteEnable,
    output logic                  IFID_WriteEnable,
    output logic                  WriteEnableMuxControl,
    output logic                  MDU_Busy,
    output logic [CNT_W-1:0]      StallCount
);

    // Down-counter width for the MDU; at least one bit so a latency of 1 still works.
    localparam int MDU_CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;

    // Source operands of the ID instruction, indexed 0 = rs, 1 = rt.
    logic [1:0][REG_ADDR_W-1:0] src_reg;
    logic [1:0]                 src_used;
    logic [1:0]                 ex_hit;
    logic [1:0]                 mem_hit;

    logic match_ex;
    logic match_mem;
    logic load_use;
    logic br_haz;
    logic mdu_haz;
    logic mdu_busy;
    logic stall;

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;

    assign src_reg[0]  = ID_Rs;
    assign src_reg[1]  = ID_Rt;
    assign src_used[0] = ID_UsesRs;
    assign src_used[1] = ID_UsesRt;

    // Per-operand comparison against the EX and MEM destinations. A source of
    // $0 never matches, which also covers a destination of $0.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi]  = src_used[gi] && (src_reg[gi] != '0) &&
                                 (src_reg[gi] == EX_WriteReg);
            assign mem_hit[gi] = src_used[gi] && (src_reg[gi] != '0) &&
                                 (src_reg[gi] == MEM_WriteReg);
        end
    endgenerate

    assign match_ex  = |ex_hit;
    assign match_mem = |mem_hit;

    // A load in EX cannot forward its data to ID's consumer in time.
    assign load_use = EX_MemRead && match_ex;

    // Branches compared in ID also need any EX result and a MEM load result.
    generate
        if (BRANCH_IN_ID != 0) begin : g_br
            assign br_haz = ID_IsBranch &&
                            ((EX_RegWrite && match_ex) || (MEM_MemRead && match_mem));
        end else begin : g_no_br
            assign br_haz = 1'b0;
        end
    endgenerate

    // HI/LO readers and new MDU ops wait until the current MDU op is done.
    assign mdu_haz = mdu_busy && (ID_ReadsHiLo || ID_IsMDU);

    assign stall = load_use || br_haz || mdu_haz;

    // While reset is held the pipeline must be free to run, whatever the inputs.
    assign PC_WriteEnable        = !stall || !Reset;
    assign IFID_WriteEnable      = !stall || !Reset;
    assign WriteEnableMuxControl = !stall || !Reset;
    assign MDU_Busy              = mdu_busy;

    generate
        if (MDU_LATENCY > 0) begin : g_mdu
            localparam logic [0:0] ST_IDLE = 1'b0;
            localparam logic [0:0] ST_BUSY = 1'b1;
            localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);

            logic [0:0]           state_reg;
            logic [0:0]           state_next;
            logic [MDU_CNT_W-1:0] cnt_reg;
            logic [MDU_CNT_W-1:0] cnt_next;

            // Accept an MDU op only when the ID instruction actually advances;
            // count down the remaining busy cycles, then return to idle.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (ID_IsMDU && !stall) begin
                            state_next = ST_BUSY;
                            cnt_next   = CNT_LOAD;
                        end
                    end
                    ST_BUSY: begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - MDU_CNT_W'(1);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            // MDU tracking state; reset abandons any operation in flight.
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            assign mdu_busy = (state_reg == ST_BUSY);
        end else begin : g_no_mdu
            assign mdu_busy = 1'b0;
        end
    endgenerate

    // Saturating increment: sticks at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNT_W'(1);
        end
    end

    // Stall-cycle performance counter.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign StallCount = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_detection_unit_param.sv
// Bench for hazard_detection_unit_param. Three instances share one set of
// inputs: (A) branch-in-ID, 4-cycle MDU, 3-bit counter; (B) load-use only,
// no MDU, 16-bit counter; (C) default parameters. A reference model that
// tracks "cycles of MDU work remaining" and a plain stall tally per instance
// is compared against every instance on every falling clock edge.
module tb_hazard_detection_unit_param;

    localparam int NI = 3;
    localparam int BR_P  [NI] = '{1, 0, 1};
    localparam int LAT_P [NI] = '{4, 0, 32};
    localparam int CW_P  [NI] = '{3, 16, 16};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_wr = '0, mem_wr = '0;
    logic       uses_rs = 1'b0, uses_rt = 1'b0, is_branch = 1'b0, is_mdu = 1'b0;
    logic       reads_hilo = 1'b0, ex_memread = 1'b0, ex_regwrite = 1'b0, mem_memread = 1'b0;

    logic        en_pc   [NI];
    logic        en_ifid [NI];
    logic        en_mux  [NI];
    logic        busy    [NI];
    logic [2:0]  cnt_a;
    logic [15:0] cnt_b, cnt_c;
    logic [15:0] dut_cnt [NI];

    assign dut_cnt[0] = {13'b0, cnt_a};
    assign dut_cnt[1] = cnt_b;
    assign dut_cnt[2] = cnt_c;

    always #5 clk = ~clk;

    hazard_detection_unit_param #(.REG_ADDR_W(5), .BRANCH_IN_ID(1), .MDU_LATENCY(4), .CNT_W(3)) dut_a (
        .Clock(clk), .Reset(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_IsBranch(is_branch),
        .ID_IsMDU(is_mdu), .ID_ReadsHiLo(reads_hilo), .EX_MemRead(ex_memread),
        .EX_RegWrite(ex_regwrite), .EX_WriteReg(ex_wr), .MEM_MemRead(mem_memread),
        .MEM_WriteReg(mem_wr), .PC_WriteEnable(en_pc[0]), .IFID_WriteEnable(en_ifid[0]),
        .WriteEnableMuxControl(en_mux[0]), .MDU_Busy(busy[0]), .StallCount(cnt_a));

    hazard_detection_unit_param #(.REG_ADDR_W(5), .BRANCH_IN_ID(0), .MDU_LATENCY(0), .CNT_W(16)) dut_b (
        .Clock(clk), .Reset(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_IsBranch(is_branch),
        .ID_IsMDU(is_mdu), .ID_ReadsHiLo(reads_hilo), .EX_MemRead(ex_memread),
        .EX_RegWrite(ex_regwrite), .EX_WriteReg(ex_wr), .MEM_MemRead(mem_memread),
        .MEM_WriteReg(mem_wr), .PC_WriteEnable(en_pc[1]), .IFID_WriteEnable(en_ifid[1]),
        .WriteEnableMuxControl(en_mux[1]), .MDU_Busy(busy[1]), .StallCount(cnt_b));

    hazard_detection_unit_param dut_c (
        .Clock(clk), .Reset(reset_n), .ID_Rs(id_rs), .ID_Rt(id_rt),
        .ID_UsesRs(uses_rs), .ID_UsesRt(uses_rt), .ID_IsBranch(is_branch),
        .ID_IsMDU(is_mdu), .ID_ReadsHiLo(reads_hilo), .EX_MemRead(ex_memread),
        .EX_RegWrite(ex_regwrite), .EX_WriteReg(ex_wr), .MEM_MemRead(mem_memread),
        .MEM_WriteReg(mem_wr), .PC_WriteEnable(en_pc[2]), .IFID_WriteEnable(en_ifid[2]),
        .WriteEnableMuxControl(en_mux[2]), .MDU_Busy(busy[2]), .StallCount(cnt_c));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference state: remaining MDU busy cycles and stall tally per instance.
    int busy_left [NI] = '{0, 0, 0};
    int stalls_m  [NI] = '{0, 0, 0};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit mx(input logic [4:0] r);
        return (r != 0) && ((uses_rs && id_rs == r) || (uses_rt && id_rt == r));
    endfunction

    function automatic bit m_stall(input int k);
        bit lu, br, md;
        lu = ex_memread && mx(ex_wr);
        br = (BR_P[k] != 0) && is_branch &&
             ((ex_regwrite && mx(ex_wr)) || (mem_memread && mx(mem_wr)));
        md = (busy_left[k] > 0) && (reads_hilo || is_mdu);
        return lu || br || md;
    endfunction

    // Reference model advance on each clock edge / reset.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NI; k++) begin
                busy_left[k] = 0;
                stalls_m[k]  = 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                bit s;
                int mx_cnt;
                s = m_stall(k);
                mx_cnt = (1 << CW_P[k]) - 1;
                if (busy_left[k] > 0) busy_left[k] = busy_left[k] - 1;
                else if (LAT_P[k] > 0 && is_mdu && !s) busy_left[k] = LAT_P[k];
                if (s && stalls_m[k] < mx_cnt) stalls_m[k] = stalls_m[k] + 1;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                int exp_en;
                exp_en = reset_n ? int'(!m_stall(k)) : 1;
                check($sformatf("pc_en[%0d]", k),   int'(en_pc[k]),   exp_en);
                check($sformatf("ifid_en[%0d]", k), int'(en_ifid[k]), exp_en);
                check($sformatf("mux_en[%0d]", k),  int'(en_mux[k]),  exp_en);
                check($sformatf("busy[%0d]", k),    int'(busy[k]),    int'(busy_left[k] > 0));
                check($sformatf("count[%0d]", k),   int'(dut_cnt[k]), stalls_m[k]);
            end
        end
    end

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_wr = '0; mem_wr = '0;
        uses_rs = 0; uses_rt = 0; is_branch = 0; is_mdu = 0;
        reads_hilo = 0; ex_memread = 0; ex_regwrite = 0; mem_memread = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        clear_in();
        step();
        chk_en = 1'b1;

        // Reset held with a load-use pattern on the inputs: enables forced high.
        ex_memread = 1; ex_wr = 8; id_rs = 8; uses_rs = 1;
        @(negedge clk);
        check("rst_force_en_a", int'(en_pc[0]), 1);
        check("rst_count_a", int'(cnt_a), 0);
        $display("txn reset-hold: en=%0b cnt=%0d", en_pc[0], cnt_a);

        // Load-use on $t0: one stall cycle, counter 0 -> 1.
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("lu_en_a", int'(en_pc[0]), 0);
        check("lu_en_b", int'(en_mux[1]), 0);
        step();
        clear_in();
        @(negedge clk);
        check("lu_count_a", int'(cnt_a), 1);
        check("lu_after_en_a", int'(en_ifid[0]), 1);
        $display("txn load-use: cnt=%0d", cnt_a);

        // Load into $0 never stalls.
        step();
        ex_memread = 1; ex_wr = 0; id_rs = 0; uses_rs = 1;
        @(negedge clk);
        check("zero_reg_en_a", int'(en_pc[0]), 1);
        $display("txn zero-reg: en=%0b", en_pc[0]);

        // Branch operand hazard: stalls only where branches resolve in ID.
        step();
        clear_in();
        is_branch = 1; id_rt = 9; uses_rt = 1; ex_regwrite = 1; ex_wr = 9;
        @(negedge clk);
        check("br_en_a", int'(en_pc[0]), 0);
        check("br_en_b", int'(en_pc[1]), 1);
        $display("txn branch: en_a=%0b en_b=%0b", en_pc[0], en_pc[1]);

        // mult then mflo with a 4-cycle MDU.
        step();
        clear_in();
        do_reset();
        is_mdu = 1;
        @(negedge clk);
        check("mult_accept_en_a", int'(en_pc[0]), 1);
        step();
        is_mdu = 0; reads_hilo = 1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (en_pc[0]) break;
            if (busy[0]) n++;
            step();
        end
        check("mflo_stall_cycles_a", n, 4);
        check("mflo_count_a", int'(cnt_a), 4);
        check("mflo_busy_done_a", int'(busy[0]), 0);
        check("mflo_no_mdu_b", int'(en_pc[1]), 1);
        $display("txn mult-mflo: stalled=%0d cnt=%0d", n, cnt_a);

        // Saturation: ten stalled cycles into a 3-bit counter.
        step();
        clear_in();
        do_reset();
        ex_memread = 1; ex_wr = 5; id_rt = 5; uses_rt = 1;
        repeat (10) step();
        clear_in();
        @(negedge clk);
        check("sat_count_a", int'(cnt_a), 7);
        check("sat_count_b", int'(cnt_b), 10);
        $display("txn saturate: cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);

        // Reset mid-BUSY (cnt=2) aborts the MDU immediately.
        step();
        do_reset();
        is_mdu = 1;
        step();
        is_mdu = 0; reads_hilo = 1;
        step();
        #2;
        check("pre_rst_busy_a", int'(busy[0]), 1);
        reset_n = 1'b0;
        #1;
        check("rst_busy_a", int'(busy[0]), 0);
        check("rst_en_a", int'(en_pc[0]), 1);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_mflo_en_a", int'(en_pc[0]), 1);
        $display("txn reset-mid-busy: busy=%0b en=%0b", busy[0], en_pc[0]);

        // Randomised traffic with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset_n     = ($urandom_range(0, 199) != 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_wr       = 5'($urandom_range(0, 3));
            mem_wr      = 5'($urandom_range(0, 3));
            uses_rs     = 1'($urandom_range(0, 1));
            uses_rt     = 1'($urandom_range(0, 1));
            is_branch   = ($urandom_range(0, 3) == 0);
            is_mdu      = ($urandom_range(0, 7) == 0);
            reads_hilo  = ($urandom_range(0, 5) == 0);
            ex_memread  = ($urandom_range(0, 3) == 0);
            ex_regwrite = 1'($urandom_range(0, 1));
            mem_memread = ($urandom_range(0, 3) == 0);
            if (c % 500 == 0) $display("txn random block %0d: total=%0d", c / 500, total);
        end
        step();
        reset_n = 1'b1;
        clear_in();
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
